power_pack_ctrl: RTL

Game-side controller for the power-pack sprite block. It schedules the spawn pulse and detects the ball eating the pack. It drives the eaten level and times the resulting power-up effect. It sits between the ball/paddle logic and the power-pack sprite: it consumes the pack position and ball position, and produces the spawn, eaten, effect_active and effect_owner signals used by the sprite and paddle blocks.

---
 rtl/power_pack_pkg.sv | 23 ++
 rtl/power_pack_ctrl_tick.sv | 36 +++
 rtl/power_pack_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/power_pack_pkg.sv
// Shared types, widths and overlap helper for the power-pack controller.
package power_pack_pkg;

   localparam int FRAME_CNT_W = 10;
   localparam int X_W         = 11;
   localparam int Y_W         = 10;
   localparam int SUM_W       = 12;

   typedef enum logic [1:0] {
      ST_WAIT   = 2'd0,
      ST_LIVE   = 2'd1,
      ST_EFFECT = 2'd2
   } pp_state_t;

   // One-axis interval intersection; 12-bit operands keep edge + size from wrapping.
   function automatic logic span_overlap(input logic [SUM_W-1:0] a,
                                         input logic [SUM_W-1:0] a_len,
                                         input logic [SUM_W-1:0] b,
                                         input logic [SUM_W-1:0] b_len);
      return (a < b + b_len) && (a + a_len > b);
   endfunction

endpackage

// File: rtl/power_pack_ctrl_tick.sv
// Frame tick (vsync rising edge) plus a shared frame counter with clear and
// terminal-count compare, reused by every timed state of the controller.
module frame_tick_gen
   import power_pack_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   vsync,
   input  logic                   cnt_en,
   input  logic                   cnt_clr,
   input  logic [FRAME_CNT_W-1:0] term,
   output logic                   tick,
   output logic                   at_term
);

   logic                   vsync_q_reg;
   logic [FRAME_CNT_W-1:0] count_reg;

   assign tick    = vsync & ~vsync_q_reg;
   assign at_term = (count_reg == term);

   always_ff @(posedge clk) begin
      if (reset) begin
         vsync_q_reg <= 1'b0;
         count_reg   <= '0;
      end else begin
         vsync_q_reg <= vsync;
         if (cnt_clr) begin
            count_reg <= '0;
         end else if (tick && cnt_en) begin
            count_reg <= count_reg + 1'b1;
         end
      end
   end

endmodule

// File: rtl/power_pack_ctrl.sv
// Power-pack game controller: spawn scheduling, eat detection, effect timing.
// Optional LIVE timeout is enabled by defining POWER_PACK_TIMEOUT_EN.
module power_pack_ctrl
   import power_pack_pkg::*;
#(
   parameter int SPAWN_FRAMES  = 120,
   parameter int LIFE_FRAMES   = 300,
   parameter int EFFECT_FRAMES = 180,
   parameter int PACK_W        = 20,
   parameter int PACK_H        = 20,
   parameter int BALL_SIZE     = 16
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           vsync,
   input  logic [X_W-1:0] ball_x,
   input  logic [Y_W-1:0] ball_y,
   input  logic [X_W-1:0] pack_x,
   input  logic [Y_W-1:0] pack_y,
   input  logic           last_hit,
   output logic           spawn,
   output logic           eaten,
   output logic           effect_active,
   output logic           effect_owner,
   output logic [1:0]     state_dbg
);

   localparam logic [FRAME_CNT_W-1:0] SPAWN_TERM  = FRAME_CNT_W'(SPAWN_FRAMES - 1);
   localparam logic [FRAME_CNT_W-1:0] LIFE_TERM   = FRAME_CNT_W'(LIFE_FRAMES - 1);
   localparam logic [FRAME_CNT_W-1:0] EFFECT_TERM = FRAME_CNT_W'(EFFECT_FRAMES - 1);

   pp_state_t state_reg, state_next;
   logic      spawn_reg, spawn_next;
   logic      eaten_reg, eaten_next;
   logic      effect_active_reg, effect_active_next;
   logic      effect_owner_reg, effect_owner_next;

   logic                   tick, at_term, cnt_en, cnt_clr, hit;
   logic [FRAME_CNT_W-1:0] term;

   frame_tick_gen u_tick (
      .clk     (clk),
      .reset   (reset),
      .vsync   (vsync),
      .cnt_en  (cnt_en),
      .cnt_clr (cnt_clr),
      .term    (term),
      .tick    (tick),
      .at_term (at_term)
   );

   assign hit = span_overlap(SUM_W'(ball_x), SUM_W'(BALL_SIZE), SUM_W'(pack_x), SUM_W'(PACK_W)) &&
                span_overlap(SUM_W'(ball_y), SUM_W'(BALL_SIZE), SUM_W'(pack_y), SUM_W'(PACK_H));

   always_comb begin
      state_next         = state_reg;
      spawn_next         = 1'b0;
      eaten_next         = eaten_reg;
      effect_active_next = effect_active_reg;
      effect_owner_next  = effect_owner_reg;
      cnt_en             = 1'b0;
      cnt_clr            = 1'b0;
      term               = SPAWN_TERM;
      case (state_reg)
         ST_WAIT: begin
            cnt_en = 1'b1;
            if (tick && at_term) begin
               spawn_next = 1'b1;
               eaten_next = 1'b0;
               cnt_clr    = 1'b1;
               state_next = ST_LIVE;
            end
         end
         ST_LIVE: begin
            term       = LIFE_TERM;
            eaten_next = 1'b0;
`ifdef POWER_PACK_TIMEOUT_EN
            cnt_en = 1'b1;
`endif
            if (tick && hit) begin
               eaten_next         = 1'b1;
               effect_active_next = 1'b1;
               effect_owner_next  = last_hit;
               cnt_clr            = 1'b1;
               state_next         = ST_EFFECT;
            end
`ifdef POWER_PACK_TIMEOUT_EN
            else if (tick && at_term) begin
               eaten_next = 1'b1;
               cnt_clr    = 1'b1;
               state_next = ST_WAIT;
            end
`endif
         end
         ST_EFFECT: begin
            term   = EFFECT_TERM;
            cnt_en = 1'b1;
            if (tick && at_term) begin
               effect_active_next = 1'b0;
               cnt_clr            = 1'b1;
               state_next         = ST_WAIT;
            end
         end
         default: begin
            // Unused encoding: park the pack and restart the spawn schedule.
            eaten_next         = 1'b1;
            effect_active_next = 1'b0;
            cnt_clr            = 1'b1;
            state_next         = ST_WAIT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg         <= ST_WAIT;
         spawn_reg         <= 1'b0;
         eaten_reg         <= 1'b1;
         effect_active_reg <= 1'b0;
         effect_owner_reg  <= 1'b0;
      end else begin
         state_reg         <= state_next;
         spawn_reg         <= spawn_next;
         eaten_reg         <= eaten_next;
         effect_active_reg <= effect_active_next;
         effect_owner_reg  <= effect_owner_next;
      end
   end

   assign spawn         = spawn_reg;
   assign eaten         = eaten_reg;
   assign effect_active = effect_active_reg;
   assign effect_owner  = effect_owner_reg;
   assign state_dbg     = state_reg;

endmodule
